// File: rtl/tanimoto_pkg.sv
// Shared definitions for the Tanimoto ID-pair merge path: default lane count,
// vector ID width, pair width and the merge FSM state encoding.
package tanimoto_pkg;

  localparam int N_LANES      = 4;
  localparam int VEC_ID_WIDTH = 8;
  localparam int PW           = 2 * VEC_ID_WIDTH;

  // RUN accepts pairs from the lanes; DRAIN waits for the tlast beat to leave.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } arb_state_t;

  // One pair carries two vector IDs.
  function automatic int pair_width(input int vec_id_width);
    return 2 * vec_id_width;
  endfunction

  // Width of a round-robin pointer able to name every lane.
  function automatic int ptr_width(input int n_lanes);
    return (n_lanes < 2) ? 1 : $clog2(n_lanes);
  endfunction

endpackage

// File: rtl/idpair_arbiter_rr.sv
// Masked round-robin grant: picks the first unmasked requester at or after the
// pointer position, wrapping around, and returns it one-hot (or zero).
module rr_arbiter
  import tanimoto_pkg::*;
#(
  parameter int N     = N_LANES,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     i_Req,
  input  logic [N-1:0]     i_Mask,
  input  logic [PTR_W-1:0] i_Ptr,
  output logic [N-1:0]     o_Grant
);

  logic [N-1:0] w_Eligible;
  logic         w_Found;

  assign w_Eligible = i_Req & ~i_Mask;

  // Scan lanes starting from the pointer and grant the first eligible one.
  always_comb begin
    o_Grant = '0;
    w_Found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (int'(i_Ptr) + i) % N;
      if (!w_Found && w_Eligible[idx]) begin
        o_Grant[idx] = 1'b1;
        w_Found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/idpair_arbiter.sv
// Merges the ID pairs of several comparator lanes into one AXI-Stream output.
// Lanes are served round-robin; a lane that delivered its last pair of the job
// is parked until every lane has done so, and the beat completing the job
// carries tlast. The next job starts only after that beat leaves.
module idpair_arbiter
  import tanimoto_pkg::*;
#(
  parameter int  N_LANES      = tanimoto_pkg::N_LANES,
  parameter int  VEC_ID_WIDTH = tanimoto_pkg::VEC_ID_WIDTH,
  localparam int PAIR_W       = pair_width(VEC_ID_WIDTH)
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [N_LANES*PAIR_W-1:0]   i_Pair_Data,
  input  logic [N_LANES-1:0]          i_Pair_Valid,
  input  logic [N_LANES-1:0]          i_Pair_Last,
  output logic [N_LANES-1:0]          o_Pair_Read,
  output logic [PAIR_W-1:0]           M_AXIS_ID_PAIR_tdata,
  output logic                        M_AXIS_ID_PAIR_tvalid,
  output logic                        M_AXIS_ID_PAIR_tlast,
  input  logic                        M_AXIS_ID_PAIR_tready,
  output logic                        o_Job_Done,
  output logic [31:0]                 o_Pair_Count
);

  localparam int PTR_W = ptr_width(N_LANES);

  arb_state_t          r_State, w_NextState;
  logic [N_LANES-1:0]  r_Done, w_DoneNext, w_Grant, w_Mask;
  logic [PTR_W-1:0]    r_Ptr, w_NextPtr;
  logic                r_Valid, r_Last, r_JobDone;
  logic [PAIR_W-1:0]   r_Data, w_SelData;
  logic [31:0]         r_Count;
  logic                w_CanLoad, w_Load, w_JobComplete, w_OutAccept, w_TlastAccept;

  // The output stage can take a new pair when empty or being emptied this cycle,
  // so a lane can be granted in the very cycle the stage drains.
  assign w_CanLoad     = !r_Valid || M_AXIS_ID_PAIR_tready;
  assign w_Mask        = r_Done | {N_LANES{(r_State != ST_RUN) || !w_CanLoad}};
  assign w_Load        = |w_Grant;
  assign w_DoneNext    = r_Done | (w_Grant & i_Pair_Last);
  assign w_JobComplete = w_Load && (&w_DoneNext);
  assign w_OutAccept   = r_Valid && M_AXIS_ID_PAIR_tready;
  assign w_TlastAccept = w_OutAccept && r_Last;

  rr_arbiter #(
    .N     (N_LANES),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_Req   (i_Pair_Valid),
    .i_Mask  (w_Mask),
    .i_Ptr   (r_Ptr),
    .o_Grant (w_Grant)
  );

  // Route the granted lane's pair and compute the pointer that follows it.
  always_comb begin
    w_SelData = '0;
    w_NextPtr = r_Ptr;
    for (int k = 0; k < N_LANES; k++) begin
      if (w_Grant[k]) begin
        w_SelData = i_Pair_Data[k*PAIR_W +: PAIR_W];
        w_NextPtr = PTR_W'((k + 1) % N_LANES);
      end
    end
  end

  // Next-state logic: stop granting once the job-ending pair is registered.
  always_comb begin
    w_NextState = r_State;
    case (r_State)
      ST_RUN:   if (w_JobComplete) w_NextState = ST_DRAIN;
      ST_DRAIN: if (w_TlastAccept) w_NextState = ST_RUN;
      default:  w_NextState = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_State <= ST_RUN;
    else        r_State <= w_NextState;
  end

  // Per-lane done flags and round-robin pointer; flags clear as the job ends.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_Done <= '0;
      r_Ptr  <= '0;
    end else begin
      if (r_State == ST_DRAIN && w_TlastAccept) r_Done <= '0;
      else                                      r_Done <= w_DoneNext;
      if (w_Load) r_Ptr <= w_NextPtr;
    end
  end

  // Single output register; holds its contents while stalled downstream.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_Valid <= 1'b0;
      r_Data  <= '0;
      r_Last  <= 1'b0;
    end else if (w_CanLoad) begin
      r_Valid <= w_Load;
      r_Last  <= w_JobComplete;
      if (w_Load) r_Data <= w_SelData;
    end
  end

  // Job-done pulse and saturating beat count; the count shows the job total
  // during the pulse cycle and returns to zero right after.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_JobDone <= 1'b0;
      r_Count   <= '0;
    end else begin
      r_JobDone <= w_TlastAccept;
      if (r_JobDone)                          r_Count <= 32'(w_OutAccept);
      else if (w_OutAccept && r_Count != '1)  r_Count <= r_Count + 32'd1;
    end
  end

  assign o_Pair_Read           = w_Grant & {N_LANES{!ap_rst}};
  assign M_AXIS_ID_PAIR_tdata  = r_Data;
  assign M_AXIS_ID_PAIR_tvalid = r_Valid;
  assign M_AXIS_ID_PAIR_tlast  = r_Last;
  assign o_Job_Done            = r_JobDone;
  assign o_Pair_Count          = r_Count;

endmodule

// File: tb/tb_idpair_arbiter.sv
// Directed bench for idpair_arbiter: reset state, round-robin order, stall
// hold, job framing, done-lane masking, mid-job reset and a random merge run.
module tb_idpair_arbiter;
  import tanimoto_pkg::*;

  localparam int NL  = 4;
  localparam int VW  = 8;
  localparam int PWL = 2 * VW;

  logic              ap_clk;
  logic              ap_rst;
  logic [NL*PWL-1:0] i_Pair_Data;
  logic [NL-1:0]     i_Pair_Valid;
  logic [NL-1:0]     i_Pair_Last;
  logic [NL-1:0]     o_Pair_Read;
  logic [PWL-1:0]    M_AXIS_ID_PAIR_tdata;
  logic              M_AXIS_ID_PAIR_tvalid;
  logic              M_AXIS_ID_PAIR_tlast;
  logic              M_AXIS_ID_PAIR_tready;
  logic              o_Job_Done;
  logic [31:0]       o_Pair_Count;

  idpair_arbiter #(
    .N_LANES      (NL),
    .VEC_ID_WIDTH (VW)
  ) dut (
    .ap_clk                (ap_clk),
    .ap_rst                (ap_rst),
    .i_Pair_Data           (i_Pair_Data),
    .i_Pair_Valid          (i_Pair_Valid),
    .i_Pair_Last           (i_Pair_Last),
    .o_Pair_Read           (o_Pair_Read),
    .M_AXIS_ID_PAIR_tdata  (M_AXIS_ID_PAIR_tdata),
    .M_AXIS_ID_PAIR_tvalid (M_AXIS_ID_PAIR_tvalid),
    .M_AXIS_ID_PAIR_tlast  (M_AXIS_ID_PAIR_tlast),
    .M_AXIS_ID_PAIR_tready (M_AXIS_ID_PAIR_tready),
    .o_Job_Done            (o_Job_Done),
    .o_Pair_Count          (o_Pair_Count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Lane sources hold {lane_last, pair}; observed beats hold {tlast, tdata}.
  logic [16:0] laneQ [NL][$];
  logic [15:0] expQ  [NL][$];
  logic [16:0] obsQ  [$];
  logic [NL-1:0] laneEn;
  int assertCount = 0;
  int failCount   = 0;
  int jobPulses   = 0;

  logic [16:0] expA [10];
  logic [16:0] expB [14];
  int          jobTotals [$];
  int          p0, cyc, jobIdx, beatInJob, numJobs, total, len;
  logic [31:0] cntAtPulse, cntAfter;
  logic [16:0] beat;
  logic [7:0]  seqK [NL];
  logic        seenPulse, legal;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic present();
    logic [NL*PWL-1:0] d;
    logic [NL-1:0]     v, l;
    d = '0; v = '0; l = '0;
    for (int k = 0; k < NL; k++) begin
      if (laneEn[k] && laneQ[k].size() > 0) begin
        v[k]             = 1'b1;
        d[k*PWL +: PWL]  = laneQ[k][0][15:0];
        l[k]             = laneQ[k][0][16];
      end
    end
    i_Pair_Data  = d;
    i_Pair_Valid = v;
    i_Pair_Last  = l;
  endtask

  // One clock: note transfers, take the edge, pop accepted pairs, re-present.
  task automatic applyStimulus();
    logic [NL-1:0] acc;
    logic          outAcc;
    logic [16:0]   outBeat;
    acc     = i_Pair_Valid & o_Pair_Read;
    outAcc  = M_AXIS_ID_PAIR_tvalid && M_AXIS_ID_PAIR_tready;
    outBeat = {M_AXIS_ID_PAIR_tlast, M_AXIS_ID_PAIR_tdata};
    @(posedge ap_clk);
    #1;
    if (outAcc) obsQ.push_back(outBeat);
    for (int k = 0; k < NL; k++)
      if (acc[k] && laneQ[k].size() > 0) void'(laneQ[k].pop_front());
    if (o_Job_Done) jobPulses++;
    present();
    #1;
  endtask

  task automatic loadLane(input int k, input int n, input logic withLast);
    for (int i = 0; i < n; i++)
      laneQ[k].push_back({withLast && (i == n - 1), 8'(k), 8'(i)});
  endtask

  task automatic clearAll();
    for (int k = 0; k < NL; k++) laneQ[k].delete();
    obsQ.delete();
    laneEn = '0;
  endtask

  task automatic doReset();
    clearAll();
    present();
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    #1;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expA = '{17'h00000, 17'h00100, 17'h00200, 17'h00300, 17'h00001,
             17'h00201, 17'h00301, 17'h00002, 17'h00302, 17'h10303};
    expB = '{17'h00000, 17'h00100, 17'h00200, 17'h00300, 17'h00001,
             17'h00201, 17'h00301, 17'h00002, 17'h00202, 17'h00302,
             17'h00003, 17'h00203, 17'h10303, 17'h00101};
    ap_rst = 1'b1;
    M_AXIS_ID_PAIR_tready = 1'b1;
    clearAll();

    // Reset state with every lane requesting.
    for (int k = 0; k < NL; k++) loadLane(k, 8, 1'b1);
    laneEn = '1;
    present();
    repeat (2) @(posedge ap_clk);
    #1;
    checkOutput("rst_tvalid", M_AXIS_ID_PAIR_tvalid, 0);
    checkOutput("rst_tlast",  M_AXIS_ID_PAIR_tlast, 0);
    checkOutput("rst_tdata",  M_AXIS_ID_PAIR_tdata, 0);
    checkOutput("rst_read",   o_Pair_Read, 0);
    checkOutput("rst_jobdone", o_Job_Done, 0);
    checkOutput("rst_count",  o_Pair_Count, 0);

    // All lanes valid, tready high: grants 0,1,2,3,0,... one per cycle.
    ap_rst = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      checkOutput("rr_read", o_Pair_Read, 32'(1 << (c % 4)));
      applyStimulus();
      checkOutput("rr_tvalid", M_AXIS_ID_PAIR_tvalid, 1);
      checkOutput("rr_tdata", M_AXIS_ID_PAIR_tdata, {8'(c % 4), 8'(c / 4)});
    end
    p0 = jobPulses; cyc = 0;
    while (jobPulses == p0 && cyc < 80) begin applyStimulus(); cyc++; end
    checkOutput("rr_jobdone_seen", jobPulses - p0, 1);
    checkOutput("rr_beats", obsQ.size(), 32);
    for (int n = 0; n < 32 && n < obsQ.size(); n++)
      checkOutput("rr_beat", obsQ[n], {(n == 31), 8'(n % 4), 8'(n / 4)});

    // Lane 2 alone with tready low: first pair held, lane not read while stalled.
    doReset();
    laneQ[2].push_back(17'h01234);
    laneQ[2].push_back(17'h05678);
    laneEn = 4'b0100;
    M_AXIS_ID_PAIR_tready = 1'b0;
    present();
    #1;
    checkOutput("hold_first_read", o_Pair_Read, 4'b0100);
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_tvalid", M_AXIS_ID_PAIR_tvalid, 1);
      checkOutput("hold_tdata", M_AXIS_ID_PAIR_tdata, 16'h1234);
      checkOutput("hold_read", o_Pair_Read, 0);
      applyStimulus();
    end
    M_AXIS_ID_PAIR_tready = 1'b1;
    #1;
    checkOutput("nobubble_read", o_Pair_Read, 4'b0100);
    applyStimulus();
    checkOutput("nobubble_tdata", M_AXIS_ID_PAIR_tdata, 16'h5678);
    checkOutput("nobubble_tvalid", M_AXIS_ID_PAIR_tvalid, 1);
    checkOutput("nobubble_obs", obsQ.size() > 0 ? obsQ[0] : 17'h1ffff, 17'h01234);

    // Reset while tvalid is high mid-job; next job restarts from lane 0.
    M_AXIS_ID_PAIR_tready = 1'b0;
    clearAll();
    for (int k = 0; k < NL; k++) laneQ[k].push_back({1'b0, 8'(k), 8'h55});
    laneEn = '1;
    present();
    ap_rst = 1'b1;
    #1;
    checkOutput("midrst_tvalid", M_AXIS_ID_PAIR_tvalid, 0);
    checkOutput("midrst_tlast", M_AXIS_ID_PAIR_tlast, 0);
    checkOutput("midrst_tdata", M_AXIS_ID_PAIR_tdata, 0);
    checkOutput("midrst_read", o_Pair_Read, 0);
    checkOutput("midrst_jobdone", o_Job_Done, 0);
    checkOutput("midrst_count", o_Pair_Count, 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    M_AXIS_ID_PAIR_tready = 1'b1;
    #1;
    checkOutput("midrst_ptr0_read", o_Pair_Read, 4'b0001);
    applyStimulus();
    checkOutput("midrst_next_tdata", M_AXIS_ID_PAIR_tdata, 16'h0055);
    checkOutput("midrst_next_tlast", M_AXIS_ID_PAIR_tlast, 0);

    // Lanes send 3,1,2,4 pairs: tlast on beat 10 only, count 10 then 0.
    doReset();
    loadLane(0, 3, 1'b1); loadLane(1, 1, 1'b1); loadLane(2, 2, 1'b1); loadLane(3, 4, 1'b1);
    laneEn = '1;
    present();
    #1;
    p0 = jobPulses; seenPulse = 1'b0; cntAtPulse = '1; cntAfter = '1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus();
      if (o_Job_Done) begin
        cntAtPulse = o_Pair_Count;
        seenPulse  = 1'b1;
      end else if (seenPulse && cntAfter == '1) begin
        cntAfter = o_Pair_Count;
      end
    end
    checkOutput("job_pulses", jobPulses - p0, 1);
    checkOutput("job_count_at_done", cntAtPulse, 10);
    checkOutput("job_count_after", cntAfter, 0);
    checkOutput("job_beats", obsQ.size(), 10);
    for (int n = 0; n < 10 && n < obsQ.size(); n++)
      checkOutput("job_beat", obsQ[n], expA[n]);

    // Lane 1 finishes early and stays valid: parked until the job ends.
    doReset();
    loadLane(0, 4, 1'b1);
    laneQ[1].push_back(17'h10100);
    laneQ[1].push_back(17'h00101);
    loadLane(2, 4, 1'b1);
    loadLane(3, 4, 1'b1);
    laneEn = '1;
    present();
    #1;
    p0 = jobPulses;
    for (int c = 0; c < 40; c++) applyStimulus();
    checkOutput("park_pulses", jobPulses - p0, 1);
    checkOutput("park_beats", obsQ.size(), 14);
    for (int n = 0; n < 14 && n < obsQ.size(); n++)
      checkOutput("park_beat", obsQ[n], expB[n]);

    // Random valid/tready: per-lane order preserved, no loss, tlast framing.
    doReset();
    numJobs = 60;
    jobTotals.delete();
    for (int k = 0; k < NL; k++) begin expQ[k].delete(); seqK[k] = '0; end
    for (int j = 0; j < numJobs; j++) begin
      total = 0;
      for (int k = 0; k < NL; k++) begin
        len = int'($urandom_range(1, 6));
        for (int i = 0; i < len; i++) begin
          laneQ[k].push_back({(i == len - 1), 8'(k), seqK[k]});
          expQ[k].push_back({8'(k), seqK[k]});
          seqK[k] = seqK[k] + 8'd1;
        end
        total += len;
      end
      jobTotals.push_back(total);
    end
    p0 = jobPulses; jobIdx = 0; beatInJob = 0; cyc = 0;
    while (jobIdx < numJobs && cyc < 20000) begin
      M_AXIS_ID_PAIR_tready = ($urandom_range(0, 3) != 0);
      laneEn = NL'($urandom);
      present();
      #1;
      legal = $onehot0(o_Pair_Read) && ((o_Pair_Read & ~i_Pair_Valid) == '0);
      checkOutput("rnd_read_legal", legal, 1);
      applyStimulus();
      cyc++;
      while (obsQ.size() > 0) begin
        beat = obsQ.pop_front();
        if (beat[15:8] < NL && expQ[beat[15:8]].size() > 0)
          checkOutput("rnd_order", beat[15:0], expQ[beat[15:8]].pop_front());
        else
          checkOutput("rnd_unexpected", beat[15:0], 32'hFFFF_FFFF);
        if (jobIdx < numJobs) begin
          checkOutput("rnd_tlast", beat[16], (beatInJob == jobTotals[jobIdx] - 1));
          beatInJob++;
          if (beatInJob == jobTotals[jobIdx]) begin
            jobIdx++;
            beatInJob = 0;
          end
        end
      end
    end
    repeat (3) applyStimulus();
    checkOutput("rnd_jobs_done", jobIdx, numJobs);
    checkOutput("rnd_pulses", jobPulses - p0, numJobs);
    for (int k = 0; k < NL; k++) checkOutput("rnd_lane_empty", expQ[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
